reg_shift_engine: RTL and testbench
===================================

# reg_shift_engine

Parametrised register-file shift engine: a DEPTH x WIDTH register file with a host write port and an asynchronous read port, plus a command-driven shift unit that reads a source register, shifts or rotates it, and writes the result back to a destination register. It replaces the 8-bit fixed left/right shift-and-reload datapath with a valid/ready command interface, five shift modes, and a sequenced read/shift/write FSM. It sits beside the ALU datapath in the lab CPU as the shift/rotate execution unit.

## Interface
- WIDTH, 8, data width in bits (power of two, >= 4)
- DEPTH, 8, number of registers (power of two, >= 2); AW = $clog2(DEPTH), SW = $clog2(WIDTH)
- clk  in  1  rising-edge clock; one clock domain
- reset  in  1  asynchronous, active-low reset
- wr  in  1  host write enable
- wr_addr  in  AW  host write address
- d_in  in  WIDTH  host write data
- wr_busy  out  1  high while the FSM owns the write port; host writes are ignored while high
- rd_addr  in  AW  host read address
- d_out  out  WIDTH  regs[rd_addr], combinational
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
- cmd_src  in  AW  source register
- cmd_dst  in  AW  destination register
- cmd_amt  in  SW  shift amount, 0..WIDTH-1
- done  out  1  one-cycle pulse when a command retires
- err  out  1  valid with done; 1 means illegal op
- res_data  out  WIDTH  shifted value, valid with done and held until the next done

## Operation
- FSM states: IDLE, READ, SHIFT, WRITE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op/src/dst/amt and go to READ.
- READ: latch operand = regs[src], then go to SHIFT.
- SHIFT: register the barrel-shifter output into res_data.
  - Illegal op: res_data unchanged, set err, go to IDLE, pulse done.
  - Legal op: go to WRITE.
- WRITE: regs[dst] <= res_data; pulse done with err=0; wr_busy=1; return to IDLE.
- Modes:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: MSB replicated.
  - ROL/ROR: bits wrap modulo WIDTH.
  - amt=0 passes the operand through unchanged in all modes.
- The host write port is active in IDLE, READ and SHIFT. A host write to src in READ lands after the operand latch and is not seen by the command. In WRITE the host write is dropped.
- src==dst is legal (in-place shift).

## Timing
- Reset (async assert, sync-safe deassert):
  - All registers = 0, FSM = IDLE.
  - cmd_ready=1, done=0, err=0, res_data=0, wr_busy=0.
  - d_out = 0.
- Accept at edge N; READ in N+1, SHIFT in N+2, WRITE in N+3.
  - done is high during cycle N+3 (legal) or N+2 (illegal).
  - The written value is visible on d_out from N+4.
- cmd_ready is low from N+1 until the FSM re-enters IDLE. Throughput is one command per 4 cycles (3 for illegal).
- cmd_op/src/dst/amt need only be stable in the accept cycle.
- A reset asserted mid-command aborts it: no writeback, no done.

## Structure
- Package reg_shift_pkg: op encoding localparams (OP_SLL..OP_ROR), FSM state typedef.
- Sub-module barrel_shift_n #(WIDTH): purely combinational, log2(WIDTH) mux stages, inputs data/op/amt, output shifted data; instantiated once.
- The register file is inline in this block: one write port muxed between the host and the FSM, with the FSM having priority.

## Test plan
- Reset mid-stream: assert reset during SHIFT → done never pulses, all regs 0, cmd_ready=1 after release.
- Load r1=0x96 by host; SLL r1→r2 amt=3 → done at accept+3, res_data=0xB0, r2=0xB0, err=0.
- r3=0x96:
  - SRA amt=2 → 0xE5
  - SRL amt=2 → 0x25
  - ROL amt=4 → 0x69
  - ROR amt=1 → 0x4B
  - amt=0 → 0x96
- Illegal op 3'b111 on r1 → done at accept+2 with err=1, no register changes, res_data holds its previous value.
- Back-to-back cmd_valid held high: second command accepted exactly 4 cycles after the first. In-place ROR r4→r4 amt=1 with r4=0x01 twice → 0x80, then 0x40.
- Host write to r5 during WRITE of a command targeting r6 → r5 unchanged, wr_busy=1 that cycle. The same write issued in SHIFT succeeds.

Source files
------------

// File: rtl/reg_shift_pkg.sv
// Shared definitions for the register-file shift engine: op encodings and FSM states.
package reg_shift_pkg;

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      SHIFT,
      WRITE
   } state_t;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= OP_ROR);
   endfunction

endpackage

// File: rtl/barrel_shift_n.sv
// Combinational log2(WIDTH)-stage barrel shifter for the five shift/rotate modes.
module barrel_shift_n
   import reg_shift_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int SW = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data,
   input  logic [2:0]       op,
   input  logic [SW-1:0]    amt,
   output logic [WIDTH-1:0] shifted
);

   logic [WIDTH-1:0] stage [SW+1];

   assign stage[0] = data;

   // Stage s moves the word by 2**s when amt[s] is set; illegal ops pass through.
   for (genvar s = 0; s < SW; s++) begin : g_stage
      localparam int SH = 1 << s;
      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] moved;

      assign cur = stage[s];

      always_comb begin
         moved = cur;
         case (op)
            OP_SLL:  moved = {cur[WIDTH-SH-1:0], {SH{1'b0}}};
            OP_SRL:  moved = {{SH{1'b0}}, cur[WIDTH-1:SH]};
            OP_SRA:  moved = {{SH{cur[WIDTH-1]}}, cur[WIDTH-1:SH]};
            OP_ROL:  moved = {cur[WIDTH-SH-1:0], cur[WIDTH-1:WIDTH-SH]};
            OP_ROR:  moved = {cur[SH-1:0], cur[WIDTH-1:SH]};
            default: moved = cur;
         endcase
      end

      assign stage[s+1] = amt[s] ? moved : cur;
   end

   assign shifted = stage[SW];

endmodule

// File: rtl/reg_shift_engine.sv
// DEPTH x WIDTH register file with a host port and a read/shift/write command engine.
module reg_shift_engine
   import reg_shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int SW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] d_in,
   output logic             wr_busy,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] d_out,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AW-1:0]    cmd_src,
   input  logic [AW-1:0]    cmd_dst,
   input  logic [SW-1:0]    cmd_amt,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] res_data
);

   state_t           state;
   logic [2:0]       op_q;
   logic [AW-1:0]    src_q;
   logic [AW-1:0]    dst_q;
   logic [SW-1:0]    amt_q;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] shifted;

   logic [WIDTH-1:0] regs [DEPTH];
   logic             rf_we;
   logic [AW-1:0]    rf_addr;
   logic [WIDTH-1:0] rf_data;

   barrel_shift_n #(.WIDTH(WIDTH)) u_shift (
      .data    (operand),
      .op      (op_q),
      .amt     (amt_q),
      .shifted (shifted)
   );

   // The illegal-op done is raised on the READ->SHIFT edge so it is visible during SHIFT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         op_q      <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         amt_q     <= '0;
         operand   <= '0;
         res_data  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         cmd_ready <= 1'b1;
         wr_busy   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_q      <= cmd_op;
                  src_q     <= cmd_src;
                  dst_q     <= cmd_dst;
                  amt_q     <= cmd_amt;
                  cmd_ready <= 1'b0;
                  state     <= READ;
               end
            end
            READ: begin
               operand <= regs[src_q];
               if (!is_legal_op(op_q)) begin
                  done <= 1'b1;
                  err  <= 1'b1;
               end
               state <= SHIFT;
            end
            SHIFT: begin
               if (!is_legal_op(op_q)) begin
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  res_data <= shifted;
                  done     <= 1'b1;
                  wr_busy  <= 1'b1;
                  state    <= WRITE;
               end
            end
            WRITE: begin
               wr_busy   <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Single write port: the FSM writeback wins, host writes are dropped during WRITE.
   always_comb begin
      rf_we   = 1'b0;
      rf_addr = wr_addr;
      rf_data = d_in;
      if (state == WRITE) begin
         rf_we   = 1'b1;
         rf_addr = dst_q;
         rf_data = res_data;
      end else if (wr) begin
         rf_we = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (rf_we) begin
         regs[rf_addr] <= rf_data;
      end
   end

   assign d_out = regs[rd_addr];

endmodule

// File: tb/tb_reg_shift_engine.sv
// Self-checking bench: directed literal cases plus randomized traffic against a cycle-timeline model.
module tb_reg_shift_engine;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int SW    = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             wr = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [WIDTH-1:0] d_in = '0;
   logic [AW-1:0]    rd_addr = '0;
   logic             cmd_valid = 1'b0;
   logic [2:0]       cmd_op = '0;
   logic [AW-1:0]    cmd_src = '0;
   logic [AW-1:0]    cmd_dst = '0;
   logic [SW-1:0]    cmd_amt = '0;
   logic             wr_busy, cmd_ready, done, err;
   logic [WIDTH-1:0] d_out, res_data;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   reg_shift_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr        (wr),
      .wr_addr   (wr_addr),
      .d_in      (d_in),
      .wr_busy   (wr_busy),
      .rd_addr   (rd_addr),
      .d_out     (d_out),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .cmd_amt   (cmd_amt),
      .done      (done),
      .err       (err),
      .res_data  (res_data)
   );

   always #5 clk = ~clk;

   // Reference shift computed with plain integer arithmetic on an 8-bit word.
   function automatic logic [7:0] shift_ref(input logic [7:0] v, input int op, input int a);
      int x;
      int r;
      x = int'(v);
      case (op)
         0: r = x << a;
         1: r = x >> a;
         2: r = ((x >= 128) ? x - 256 : x) >>> a;
         3: r = (x << a) | (x >> (WIDTH - a));
         4: r = (x >> a) | (x << (WIDTH - a));
         default: r = x;
      endcase
      return 8'(r & 255);
   endfunction

   // Model timeline: age counts edges since a command was accepted (0 = free).
   logic [7:0] m_regs [DEPTH];
   int         m_age, m_op, m_src, m_dst, m_amt;
   logic [7:0] m_opnd, m_res;
   logic       m_done, m_err;
   bit         m_host;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
         m_age  = 0;
         m_done = 1'b0;
         m_err  = 1'b0;
         m_res  = '0;
         m_opnd = '0;
      end else begin
         m_done = 1'b0;
         m_err  = 1'b0;
         m_host = wr;
         if (m_age == 0) begin
            if (cmd_valid) begin
               m_op  = int'(cmd_op);
               m_src = int'(cmd_src);
               m_dst = int'(cmd_dst);
               m_amt = int'(cmd_amt);
               m_age = 1;
            end
         end else if (m_age == 1) begin
            m_opnd = m_regs[m_src];
            if (m_op > 4) begin
               m_done = 1'b1;
               m_err  = 1'b1;
            end
            m_age = 2;
         end else if (m_age == 2) begin
            if (m_op > 4) m_age = 0;
            else begin
               m_res  = shift_ref(m_opnd, m_op, m_amt);
               m_done = 1'b1;
               m_age  = 3;
            end
         end else begin
            m_regs[m_dst] = m_res;
            m_host = 1'b0;
            m_age  = 0;
         end
         if (m_host) m_regs[wr_addr] = d_in;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("cmd_ready", 32'(cmd_ready), 32'(m_age == 0));
         checkOutput("wr_busy", 32'(wr_busy), 32'(m_age == 3));
         checkOutput("done", 32'(done), 32'(m_done));
         checkOutput("res_data", 32'(res_data), 32'(m_res));
         checkOutput("d_out", 32'(d_out), 32'(m_regs[rd_addr]));
         if (m_done) checkOutput("err", 32'(err), 32'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hostWrite(input int a, input int d);
      wr      = 1'b1;
      wr_addr = AW'(a);
      d_in    = WIDTH'(d);
      tick();
      wr = 1'b0;
   endtask

   task automatic readReg(input int a, input int exp, input string name);
      rd_addr = AW'(a);
      #1;
      checkOutput(name, 32'(d_out), 32'(exp));
   endtask

   // Offers one command for exactly the accept cycle, then scrambles the fields.
   task automatic applyStimulus(input int op, input int src, input int dst, input int amt);
      cmd_valid = 1'b1;
      cmd_op    = 3'(op);
      cmd_src   = AW'(src);
      cmd_dst   = AW'(dst);
      cmd_amt   = SW'(amt);
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_src   = AW'($urandom);
      cmd_dst   = AW'($urandom);
      cmd_amt   = SW'($urandom);
   endtask

   task automatic waitDone(output int lat);
      lat = 0;
      while (!done && lat < 10) begin
         tick();
         lat++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got no done within %0d cycles", lat);
      end
   endtask

   task automatic runCmd(input int op, input int src, input int dst, input int amt,
                         input int exp_res, input string name);
      int lat;
      applyStimulus(op, src, dst, amt);
      waitDone(lat);
      checkOutput({name, "_lat"}, 32'(lat), (op > 4) ? 32'd1 : 32'd2);
      checkOutput({name, "_err"}, 32'(err), (op > 4) ? 32'd1 : 32'd0);
      checkOutput({name, "_res"}, 32'(res_data), 32'(exp_res));
      tick();
   endtask

   initial begin
      int acc [2];
      logic [7:0] rs [2];
      int n_acc, n_done;
      bit hs;

      #2 reset = 1'b0;
      #20 reset = 1'b1;
      #1;
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_res", 32'(res_data), 32'd0);
      checkOutput("rst_wr_busy", 32'(wr_busy), 32'd0);
      checkOutput("rst_d_out", 32'(d_out), 32'd0);
      chk_en = 1'b1;

      checkOutput("ref_sll", 32'(shift_ref(8'h96, 0, 3)), 32'hB0);
      checkOutput("ref_sra", 32'(shift_ref(8'h96, 2, 2)), 32'hE5);
      checkOutput("ref_ror", 32'(shift_ref(8'h96, 4, 1)), 32'h4B);

      tick();
      hostWrite(1, 8'h96);
      hostWrite(3, 8'h96);
      runCmd(0, 1, 2, 3, 8'hB0, "sll3");
      readReg(2, 8'hB0, "r2_after_sll");

      runCmd(2, 3, 7, 2, 8'hE5, "sra2");
      runCmd(1, 3, 7, 2, 8'h25, "srl2");
      runCmd(3, 3, 7, 4, 8'h69, "rol4");
      runCmd(4, 3, 7, 1, 8'h4B, "ror1");
      readReg(7, 8'h4B, "r7_after_ror");
      runCmd(2, 3, 7, 0, 8'h96, "amt0");

      runCmd(7, 1, 2, 0, 8'h96, "illegal");
      readReg(2, 8'hB0, "r2_after_illegal");
      readReg(1, 8'h96, "r1_after_illegal");

      hostWrite(4, 8'h01);
      cmd_valid = 1'b1;
      cmd_op    = 3'd4;
      cmd_src   = 3'd4;
      cmd_dst   = 3'd4;
      cmd_amt   = 3'd1;
      n_acc  = 0;
      n_done = 0;
      acc    = '{0, 0};
      rs     = '{8'h00, 8'h00};
      for (int cyc = 0; cyc < 14; cyc++) begin
         hs = cmd_ready && cmd_valid;
         tick();
         if (hs && n_acc < 2) begin
            acc[n_acc] = cyc;
            n_acc++;
            if (n_acc == 2) cmd_valid = 1'b0;
         end
         if (done && n_done < 2) begin
            rs[n_done] = res_data;
            n_done++;
         end
      end
      cmd_valid = 1'b0;
      checkOutput("b2b_accepts", 32'(n_acc), 32'd2);
      checkOutput("b2b_spacing", 32'(acc[1] - acc[0]), 32'd4);
      checkOutput("b2b_res0", 32'(rs[0]), 32'h80);
      checkOutput("b2b_res1", 32'(rs[1]), 32'h40);
      readReg(4, 8'h40, "r4_inplace");

      applyStimulus(0, 1, 6, 1);
      tick();
      tick();
      checkOutput("write_wr_busy", 32'(wr_busy), 32'd1);
      hostWrite(5, 8'h5A);
      readReg(5, 8'h00, "r5_dropped");
      readReg(6, 8'h2C, "r6_written");

      applyStimulus(0, 1, 6, 1);
      tick();
      hostWrite(5, 8'h5A);
      checkOutput("shift_then_busy", 32'(wr_busy), 32'd1);
      tick();
      readReg(5, 8'h5A, "r5_in_shift");

      applyStimulus(0, 1, 2, 1);
      tick();
      reset = 1'b0;
      #1;
      checkOutput("abort_ready", 32'(cmd_ready), 32'd1);
      checkOutput("abort_done", 32'(done), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      tick();
      tick();
      checkOutput("abort_no_done", 32'(done), 32'd0);
      for (int i = 0; i < DEPTH; i++) readReg(i, 0, "abort_reg_zero");

      for (int cyc = 0; cyc < 400; cyc++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_op    = ($urandom_range(0, 9) > 8) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         cmd_src   = AW'($urandom);
         cmd_dst   = AW'($urandom);
         cmd_amt   = SW'($urandom);
         wr        = ($urandom_range(0, 3) == 0);
         wr_addr   = AW'($urandom);
         d_in      = WIDTH'($urandom);
         rd_addr   = AW'($urandom);
         tick();
      end
      cmd_valid = 1'b0;
      wr        = 1'b0;
      for (int i = 0; i < 6; i++) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
